pos_cell_arbiter: RTL and testbench
===================================

POS_CELL_ARBITER -- requirements
Module: pos_cell_arbiter

Interface
REQ-001 Parameters (name, default, meaning), SHALL be exactly:
- DATA_WIDTH, 96, cell word width {posz, posy, posx}
- ADDR_WIDTH, 8, cell RAM address width
- PARTICLE_NUM, 220, cell RAM depth (word 0 = particle count)
REQ-002 Ports (name, direction, width, meaning), SHALL be exactly:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- rd_req  in  1  force-eval request to stream the whole cell; level, sampled in IDLE
- rd_busy  out  1  stream in progress
- rd_data  out  DATA_WIDTH  particle position
- rd_valid  out  1  rd_data qualifier
- rd_last  out  1  with final rd_valid of a stream
- rd_done  out  1  one-cycle pulse, stream complete
- wr_req  in  1  motion-update write request; held until wr_ack
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_ack  out  1  one-cycle write grant pulse
- wr_err  out  1  one-cycle pulse, write dropped (out of range)
- ram_address  out  ADDR_WIDTH  to cell RAM
- ram_data  out  DATA_WIDTH  to cell RAM
- ram_rden  out  1  to cell RAM
- ram_wren  out  1  to cell RAM
- ram_q  in  DATA_WIDTH  from cell RAM, valid 2 cycles after address/rden

Function
REQ-003 States SHALL be IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR; all ram_* outputs registered.
REQ-004 IDLE arbitration: only wr_req -> WR; only rd_req -> RD_CNT; both -> grant opposite of last grant (reset value of last grant = write, so read wins first tie).
REQ-005 Stream is non-preemptible: no write granted from RD_CNT until return to IDLE.
REQ-006 Read grant sampled at cycle T: T+1 ram_rden=1, ram_address=0 (RD_CNT); T+2, T+3 RD_WAIT, ram_rden=0.
REQ-007 At T+3, count N = ram_q[ADDR_WIDTH-1:0], clamped to PARTICLE_NUM-1 if larger.
REQ-008 N=0: rd_done pulses at T+4, no rd_valid, IDLE at T+4.
REQ-009 N>0: RD_STREAM issues addresses 1..N, one per cycle, ram_rden=1, address k at T+3+k.
REQ-010 rd_data SHALL equal ram_q; rd_valid asserted exactly 2 cycles after each streamed rden (word-0 read never flagged); rd_last with valid for address N; RD_DRAIN covers the 2 trailing cycles.
REQ-011 rd_done pulses the cycle after rd_last; state IDLE in that cycle, new grant sampled there.
REQ-012 rd_busy=1 from T+1 through the rd_last cycle inclusive.
REQ-013 Write grant at T: wr_addr/wr_data captured at T; T+1 ram_wren=1, ram_address/ram_data driven, wr_ack=1 (WR); IDLE at T+2. Max one write per 2 cycles.
REQ-014 wr_addr >= PARTICLE_NUM: ram_wren stays 0, wr_ack and wr_err both pulse at T+1.
REQ-015 Writes to address 0 permitted (count update).
REQ-016 ram_rden and ram_wren SHALL never be simultaneously 1.
REQ-017 Outside active cycles, ram_address=0, ram_data=0, ram_rden=0, ram_wren=0.

Reset
REQ-018 rst high at a clock edge: state IDLE, last grant = write, all outputs 0 next cycle.
REQ-019 Reset mid-stream aborts it: rd_valid pipeline cleared, no rd_valid/rd_last/rd_done for the aborted stream even though RAM data is in flight.
REQ-020 Reset during WR: no wr_ack if reset sampled before the ack cycle; ram_wren forced 0.

Verification
REQ-021 Word0=3, rd_req at T -> rden addr 0 at T+1; addrs 1,2,3 at T+4..T+6; rd_valid T+6..T+8; rd_last T+8; rd_done T+9.
REQ-022 Word0=0 -> rd_done at T+4, no rd_valid; word0=255 -> exactly 219 rd_valid.
REQ-023 rd_req and wr_req both high from reset -> read streams first, write acked in cycle after rd_done; repeat tie -> read next.
REQ-024 wr_req addr 5 data 0xA..A -> ram_wren addr 5 at T+1 with wr_ack; subsequent stream returns 0xA..A at particle 5. wr_addr=230 -> wr_ack+wr_err, no ram_wren.
REQ-025 wr_req asserted during stream -> no ram_wren until IDLE; rden/wren never overlap (assertion).
REQ-026 rst pulsed at T+6 of REQ-021 stream -> no rd_valid after reset, rd_busy=0, next rd_req restarts at addr 0.

Source files
------------

// File: rtl/pos_cell_arbiter.sv
// pos_cell_arbiter: shares one cell position RAM between a force-eval
// reader that streams the whole cell and a motion-update writer.
//
// Ports:
//   clk, rst              sole clock, synchronous active-high reset
//   rd_req                level request to stream the cell (sampled in IDLE)
//   rd_busy               stream in progress
//   rd_data/rd_valid      streamed particle positions and qualifier
//   rd_last/rd_done       final word marker and completion pulse
//   wr_req/wr_addr/wr_data  write request, held until wr_ack
//   wr_ack/wr_err         write grant pulse, out-of-range drop pulse
//   ram_address/ram_data/ram_rden/ram_wren  registered RAM controls
//   ram_q                 RAM read data, two cycles after address/rden
module pos_cell_arbiter #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  rd_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        RD_WAIT,
        RD_STREAM,
        RD_DRAIN,
        WR
    } state_t;

    // Largest usable count (word 0 holds the count itself).
    localparam logic [ADDR_WIDTH-1:0] MAX_N    = ADDR_WIDTH'(PARTICLE_NUM - 1);
    // One extra bit so a RAM depth of 2**ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0]   WR_LIMIT = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

    state_t                state;
    state_t                state_nx;
    logic                  last_wr;
    logic                  last_wr_nx;
    // Distinguishes the first and second cycle of RD_WAIT / RD_DRAIN.
    logic                  second;
    logic                  second_nx;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic                  rden_nx;
    logic                  wren_nx;
    logic                  ack_nx;
    logic                  err_nx;
    logic                  done_nx;
    logic                  grant_rd;
    logic                  grant_wr;
    logic                  wr_in_range;
    logic [ADDR_WIDTH-1:0] q_count;
    logic [ADDR_WIDTH-1:0] n_clamped;
    logic                  stream_issue;
    logic                  stream_final;
    // Two-stage delay matching RAM read latency for valid and last.
    logic [1:0]            v_pipe;
    logic [1:0]            l_pipe;

    assign q_count      = ram_q[ADDR_WIDTH-1:0];
    assign n_clamped    = (q_count > MAX_N) ? MAX_N : q_count;
    assign wr_in_range  = ({1'b0, wr_addr} < WR_LIMIT);
    assign stream_issue = (state == RD_STREAM);
    assign stream_final = stream_issue && (ram_address == cnt);

    assign rd_data  = ram_q;
    assign rd_valid = v_pipe[1];
    assign rd_last  = l_pipe[1];
    assign rd_busy  = (state == RD_CNT) || (state == RD_WAIT) ||
                      (state == RD_STREAM) || (state == RD_DRAIN);

    always_comb begin
        state_nx   = state;
        last_wr_nx = last_wr;
        second_nx  = 1'b0;
        cnt_nx     = cnt;
        addr_nx    = '0;
        data_nx    = '0;
        rden_nx    = 1'b0;
        wren_nx    = 1'b0;
        ack_nx     = 1'b0;
        err_nx     = 1'b0;
        done_nx    = 1'b0;
        grant_rd   = 1'b0;
        grant_wr   = 1'b0;

        unique case (state)
            IDLE: begin
                // On a tie, the side that did not win last time goes.
                grant_rd = rd_req && (!wr_req || last_wr);
                grant_wr = wr_req && !grant_rd;
                if (grant_rd) begin
                    state_nx   = RD_CNT;
                    last_wr_nx = 1'b0;
                    rden_nx    = 1'b1;
                end else if (grant_wr) begin
                    state_nx   = WR;
                    last_wr_nx = 1'b1;
                    ack_nx     = 1'b1;
                    if (wr_in_range) begin
                        wren_nx = 1'b1;
                        addr_nx = wr_addr;
                        data_nx = wr_data;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            RD_CNT: begin
                state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (!second) begin
                    second_nx = 1'b1;
                end else begin
                    // Word 0 is on ram_q now.
                    cnt_nx = n_clamped;
                    if (n_clamped == '0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RD_STREAM;
                        rden_nx  = 1'b1;
                        addr_nx  = ADDR_WIDTH'(1);
                    end
                end
            end
            RD_STREAM: begin
                if (ram_address == cnt) begin
                    state_nx = RD_DRAIN;
                end else begin
                    rden_nx = 1'b1;
                    addr_nx = ram_address + ADDR_WIDTH'(1);
                end
            end
            RD_DRAIN: begin
                if (!second) begin
                    second_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            WR: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_wr     <= 1'b1;
            second      <= 1'b0;
            cnt         <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_rden    <= 1'b0;
            ram_wren    <= 1'b0;
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            rd_done     <= 1'b0;
            v_pipe      <= '0;
            l_pipe      <= '0;
        end else begin
            state       <= state_nx;
            last_wr     <= last_wr_nx;
            second      <= second_nx;
            cnt         <= cnt_nx;
            ram_address <= addr_nx;
            ram_data    <= data_nx;
            ram_rden    <= rden_nx;
            ram_wren    <= wren_nx;
            wr_ack      <= ack_nx;
            wr_err      <= err_nx;
            rd_done     <= done_nx;
            v_pipe      <= {v_pipe[0], stream_issue};
            l_pipe      <= {l_pipe[0], stream_final};
        end
    end

endmodule

// File: tb/tb_pos_cell_arbiter.sv
// tb_pos_cell_arbiter: directed bench for pos_cell_arbiter with a RAM
// emulation, a transaction-level schedule model and literal timing pins.
module tb_pos_cell_arbiter;

    localparam int DW   = 96;
    localparam int AW   = 8;
    localparam int PN   = 220;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_busy;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_done;
    logic          wr_ack;
    logic          wr_err;
    logic          ram_rden;
    logic          ram_wren;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] ram_address;

    pos_cell_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PARTICLE_NUM(PN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_busy    (rd_busy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .rd_done    (rd_done),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_rden   (ram_rden),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM emulation: two-cycle read latency.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    always @(posedge clk) begin
        if (ram_rden) q1 <= mem[ram_address];
        q2 <= q1;
        if (ram_wren) mem[ram_address] = ram_data;
    end
    assign ram_q = q2;

    function automatic logic [DW-1:0] init_word(input int k);
        return {32'(k), 32'hC0DE0000 + 32'(k), 32'(k * 3 + 1)};
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Expected per-cycle outputs, filled in when a grant is predicted.
    typedef struct packed {
        logic          rden;
        logic          wren;
        logic          valid;
        logic          last;
        logic          done;
        logic          busy;
        logic          ack;
        logic          err;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sched [0:MAXC-1];
    logic [DW-1:0] mmem  [0:255];
    logic          m_last_wr = 1'b1;
    int            free_at   = 0;
    bit            init_done = 1'b0;

    int            rden_cyc[$];
    logic [AW-1:0] rden_adr[$];
    int            wren_cyc[$];
    logic [AW-1:0] wren_adr[$];
    int            valid_cyc[$];
    logic [DW-1:0] valid_dat[$];
    int            last_cyc[$];
    int            done_cyc[$];
    int            ack_cyc[$];
    int            err_cyc[$];

    always @(negedge clk) begin
        exp_t e;
        int   n;
        bit   gr;
        bit   gw;
        if (!init_done) begin
            for (int i = 0; i < MAXC; i++) sched[i] = '0;
            init_done = 1'b1;
        end
        e = sched[cyc];
        chk("ram_port", {ram_rden, ram_wren, ram_address, ram_data},
            {e.rden, e.wren, e.addr, e.wdata});
        chk("rd_ctrl", {rd_busy, rd_valid, rd_last, rd_done},
            {e.busy, e.valid, e.last, e.done});
        chk("wr_resp", {wr_ack, wr_err}, {e.ack, e.err});
        if (e.valid) chk("rd_data", rd_data, e.rdata);
        chk("no_overlap", ram_rden & ram_wren, 1'b0);

        if (ram_rden) begin
            rden_cyc.push_back(cyc);
            rden_adr.push_back(ram_address);
        end
        if (ram_wren) begin
            wren_cyc.push_back(cyc);
            wren_adr.push_back(ram_address);
        end
        if (rd_valid) begin
            valid_cyc.push_back(cyc);
            valid_dat.push_back(rd_data);
        end
        if (rd_last) last_cyc.push_back(cyc);
        if (rd_done) done_cyc.push_back(cyc);
        if (wr_ack)  ack_cyc.push_back(cyc);
        if (wr_err)  err_cyc.push_back(cyc);

        // Model: predict the whole transaction when a grant happens.
        if (rst) begin
            for (int i = cyc + 1; i < MAXC; i++) sched[i] = '0;
            m_last_wr = 1'b1;
            free_at   = cyc + 1;
        end else if (cyc >= free_at) begin
            gr = rd_req && (!wr_req || m_last_wr);
            gw = wr_req && !gr;
            if (gr) begin
                m_last_wr = 1'b0;
                n = int'(mmem[0][AW-1:0]);
                if (n > PN - 1) n = PN - 1;
                sched[cyc + 1].rden = 1'b1;
                sched[cyc + 1].addr = '0;
                if (n == 0) begin
                    for (int i = 1; i <= 3; i++) sched[cyc + i].busy = 1'b1;
                    sched[cyc + 4].done = 1'b1;
                    free_at = cyc + 4;
                end else begin
                    for (int i = 1; i <= 5 + n; i++)
                        sched[cyc + i].busy = 1'b1;
                    for (int k = 1; k <= n; k++) begin
                        sched[cyc + 3 + k].rden  = 1'b1;
                        sched[cyc + 3 + k].addr  = AW'(k);
                        sched[cyc + 5 + k].valid = 1'b1;
                        sched[cyc + 5 + k].rdata = mmem[k];
                    end
                    sched[cyc + 5 + n].last = 1'b1;
                    sched[cyc + 6 + n].done = 1'b1;
                    free_at = cyc + 6 + n;
                end
            end else if (gw) begin
                m_last_wr = 1'b1;
                sched[cyc + 1].ack = 1'b1;
                if (int'(wr_addr) < PN) begin
                    sched[cyc + 1].wren  = 1'b1;
                    sched[cyc + 1].addr  = wr_addr;
                    sched[cyc + 1].wdata = wr_data;
                    mmem[wr_addr] = wr_data;
                end else begin
                    sched[cyc + 1].err = 1'b1;
                end
                free_at = cyc + 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int base, input string nm);
        int n = 0;
        while (ack_cyc.size() <= base && n < 400) begin
            tick();
            n++;
        end
        chk(nm, ack_cyc.size(), base + 1);
    endtask

    task automatic wait_done(input int base, input string nm);
        int n = 0;
        while (done_cyc.size() <= base && n < 400) begin
            tick();
            n++;
        end
        chk(nm, done_cyc.size(), base + 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int t);
        int b;
        b       = ack_cyc.size();
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        t       = cyc;
        wait_ack(b, "wr_ack_wait");
        wr_req  = 1'b0;
    endtask

    task automatic do_read(output int t);
        int b;
        b      = done_cyc.size();
        rd_req = 1'b1;
        t      = cyc;
        tick();
        rd_req = 1'b0;
        wait_done(b, "rd_done_wait");
    endtask

    localparam logic [DW-1:0] PAT_A = {24{4'hA}};
    localparam logic [DW-1:0] PAT_5 = {24{4'h5}};

    initial begin
        int t, t2, br, bv, bd, ba, bw, be, na;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = init_word(i);
            mmem[i] = init_word(i);
        end
        mem[0]  = 96'd3;
        mmem[0] = 96'd3;
        rst     = 1'b1;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 8'd5;
        wr_data = PAT_A;
        repeat (3) tick();
        chk("reset_outputs",
            {rd_busy, rd_valid, rd_last, rd_done, wr_ack, wr_err,
             ram_rden, ram_wren, ram_address, ram_data}, 128'd0);

        // Tie out of reset: read first, write right after rd_done.
        rst = 1'b0;
        t  = cyc;
        br = rden_cyc.size(); bv = valid_cyc.size(); bd = done_cyc.size();
        ba = ack_cyc.size();  bw = wren_cyc.size();
        tick();
        rd_req = 1'b0;
        wait_ack(ba, "tie_ack_wait");
        wr_req = 1'b0;
        chk("tie_rden0_cyc", rden_cyc[br], t + 1);
        chk("tie_rden0_addr", rden_adr[br], 0);
        chk("tie_rden1_cyc", rden_cyc[br + 1], t + 4);
        chk("tie_rden1_addr", rden_adr[br + 1], 1);
        chk("tie_valid_n", valid_cyc.size() - bv, 3);
        chk("tie_valid_first", valid_cyc[bv], t + 6);
        chk("tie_last_cyc", last_cyc[last_cyc.size() - 1], t + 8);
        chk("tie_done_cyc", done_cyc[bd], t + 9);
        chk("tie_ack_cyc", ack_cyc[ba], t + 10);
        chk("tie_wren_cyc", wren_cyc[bw], t + 10);
        chk("tie_wren_addr", wren_adr[bw], 5);

        // Second tie: write won last, so read goes first again.
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 8'd7;
        wr_data = PAT_5;
        t  = cyc;
        br = rden_cyc.size(); ba = ack_cyc.size(); bw = wren_cyc.size();
        tick();
        rd_req = 1'b0;
        wait_ack(ba, "tie2_ack_wait");
        wr_req = 1'b0;
        chk("tie2_rden_cyc", rden_cyc[br], t + 1);
        chk("tie2_ack_cyc", ack_cyc[ba], t + 10);
        chk("tie2_wren_addr", wren_adr[bw], 7);

        // Count update through address 0, then read back particle 5.
        do_write(8'd0, 96'd6, t);
        bv = valid_cyc.size();
        do_read(t);
        chk("rb_valid_n", valid_cyc.size() - bv, 6);
        chk("rb_p1", valid_dat[bv], init_word(1));
        chk("rb_p5", valid_dat[bv + 4], PAT_A);
        chk("rb_p6", valid_dat[bv + 5], init_word(6));

        // Out-of-range writes and the last in-range address.
        be = err_cyc.size(); bw = wren_cyc.size(); ba = ack_cyc.size();
        do_write(8'd230, '1, t);
        chk("oor230_err_cyc", err_cyc[be], t + 1);
        chk("oor230_ack_cyc", ack_cyc[ba], t + 1);
        do_write(8'd220, '1, t);
        chk("oor220_err_cyc", err_cyc[be + 1], t + 1);
        chk("oor_no_wren", wren_cyc.size() - bw, 0);
        do_write(8'd219, PAT_5, t);
        chk("w219_wren_addr", wren_adr[bw], 219);
        chk("w219_no_err", err_cyc.size() - be, 2);

        // Empty cell.
        do_write(8'd0, 96'd0, t);
        bv = valid_cyc.size(); bd = done_cyc.size();
        do_read(t);
        chk("n0_done_cyc", done_cyc[bd], t + 4);
        chk("n0_no_valid", valid_cyc.size() - bv, 0);

        // Count field uses low bits only.
        do_write(8'd0, {88'h1, 8'd2}, t);
        bv = valid_cyc.size();
        do_read(t);
        chk("nlow_valid_n", valid_cyc.size() - bv, 2);

        // Oversized count clamps to PN-1.
        do_write(8'd0, 96'd255, t);
        bv = valid_cyc.size();
        do_read(t);
        chk("nmax_valid_n", valid_cyc.size() - bv, 219);
        chk("nmax_last_cyc", last_cyc[last_cyc.size() - 1], t + 224);
        chk("nmax_p219", valid_dat[bv + 218], PAT_5);

        // Write requested mid-stream waits for IDLE.
        do_write(8'd0, 96'd3, t);
        bd = done_cyc.size(); ba = ack_cyc.size(); bw = wren_cyc.size();
        rd_req = 1'b1;
        t = cyc;
        tick();
        rd_req = 1'b0;
        tick();
        wr_req  = 1'b1;
        wr_addr = 8'd9;
        wr_data = PAT_A;
        wait_ack(ba, "mid_ack_wait");
        wr_req = 1'b0;
        chk("mid_done_cyc", done_cyc[bd], t + 9);
        chk("mid_ack_cyc", ack_cyc[ba], t + 10);
        chk("mid_wren_cyc", wren_cyc[bw], t + 10);

        // Reset at T+6 aborts the stream.
        bv = valid_cyc.size(); bd = done_cyc.size();
        rd_req = 1'b1;
        t = cyc;
        tick();
        rd_req = 1'b0;
        while (cyc < t + 6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        na = 0;
        for (int i = bv; i < valid_cyc.size(); i++)
            if (valid_cyc[i] > t + 6) na++;
        chk("abort_no_valid", na, 0);
        chk("abort_no_done", done_cyc.size() - bd, 0);
        chk("abort_busy", rd_busy, 0);
        br = rden_cyc.size(); bv = valid_cyc.size();
        do_read(t2);
        chk("restart_rden_cyc", rden_cyc[br], t2 + 1);
        chk("restart_rden_addr", rden_adr[br], 0);
        chk("restart_valid_n", valid_cyc.size() - bv, 3);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
